// File: rtl/corelet_ctrl.sv
// Tile sequencer for one corelet: emits the 35-bit inst word plus xmem/pmem strobes for WS and OS passes.
// Optional `CORELET_CTRL_PERF_EN adds a saturating stall_cnt output.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8,
  parameter int W_BASE  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [cnt_bw-1:0]  n_act,
  input  logic [cnt_bw-1:0]  n_kij,
  input  logic               l0_full,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               pmem_cen,
  output logic               pmem_wen,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               busy,
  output logic               done
`ifdef CORELET_CTRL_PERF_EN
  ,output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_LD, S_K_LD, S_K_GAP, S_A_LD, S_EXEC,
    S_DRAIN, S_ACC_RD, S_ACC_WAIT, S_ACC_WB, S_DONE
  } state_t;

  localparam logic [cnt_bw-1:0]  ONE_C    = cnt_bw'(1);
  localparam logic [cnt_bw-1:0]  COL_C    = cnt_bw'(col);
  localparam logic [cnt_bw-1:0]  COL_LAST = cnt_bw'(col - 1);
  localparam logic [cnt_bw-1:0]  GAP_LAST = cnt_bw'(row + col - 1);
  localparam logic [addr_bw-1:0] W_BASE_A = addr_bw'(W_BASE);
  localparam logic [addr_bw-1:0] COL_A    = addr_bw'(col);

  function automatic logic [addr_bw-1:0] ext_addr(input logic [cnt_bw-1:0] v);
    return addr_bw'(v);
  endfunction

  state_t             state_q, state_n;
  logic [cnt_bw-1:0]  idx_q, idx_n;
  logic [cnt_bw-1:0]  kij_q, kij_n;
  logic [cnt_bw-1:0]  o_q, o_n;
  logic [cnt_bw-1:0]  n_act_q, n_act_n;
  logic [cnt_bw-1:0]  n_kij_q, n_kij_n;
  logic               mode_q, mode_n;
  logic [addr_bw-1:0] wbase_q, wbase_n;
  logic [addr_bw-1:0] pbase_q, pbase_n;
  logic [addr_bw-1:0] aaddr_q, aaddr_n;
  logic [addr_bw-1:0] pend_q, pend_n;

  logic [34:0]        inst_p0;
  logic               xmem_cen_p0;
  logic [addr_bw-1:0] xmem_addr_p0;
  logic               pmem_cen_p0;
  logic               pmem_wen_p0;
  logic [addr_bw-1:0] pmem_addr_p0;
  logic               done_p0;
  logic               busy_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      kij_q   <= '0;
      o_q     <= '0;
      n_act_q <= '0;
      n_kij_q <= '0;
      mode_q  <= 1'b0;
      wbase_q <= '0;
      pbase_q <= '0;
      aaddr_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      kij_q   <= kij_n;
      o_q     <= o_n;
      n_act_q <= n_act_n;
      n_kij_q <= n_kij_n;
      mode_q  <= mode_n;
      wbase_q <= wbase_n;
      pbase_q <= pbase_n;
      aaddr_q <= aaddr_n;
      pend_q  <= pend_n;
    end
  end

  // Each cycle decides the strobes for the next cycle; single-cycle-latency
  // follow-ups (l0_wr, pmem drain write, sfp acc) are derived from the
  // strobes currently on the outputs.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    kij_n   = kij_q;
    o_n     = o_q;
    n_act_n = n_act_q;
    n_kij_n = n_kij_q;
    mode_n  = mode_q;
    wbase_n = wbase_q;
    pbase_n = pbase_q;
    aaddr_n = aaddr_q;
    pend_n  = pend_q;

    inst_p0      = '0;
    inst_p0[2]   = ~xmem_cen;
    inst_p0[33]  = ~pmem_cen & pmem_wen;
    xmem_cen_p0  = 1'b1;
    xmem_addr_p0 = '0;
    pmem_cen_p0  = ~inst[6];
    pmem_wen_p0  = ~inst[6];
    pmem_addr_p0 = inst[6] ? pend_q : '0;
    done_p0      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_n  = mode;
          n_act_n = n_act;
          n_kij_n = n_kij;
          kij_n   = '0;
          idx_n   = '0;
          o_n     = '0;
          wbase_n = W_BASE_A;
          pbase_n = '0;
          aaddr_n = '0;
          if (n_act == '0 || (!mode && n_kij == '0)) begin
            done_p0 = 1'b1;
          end else begin
            state_n = mode ? S_A_LD : S_W_LD;
            if (!l0_full) begin
              xmem_cen_p0  = 1'b0;
              xmem_addr_p0 = mode ? '0 : W_BASE_A;
              idx_n        = ONE_C;
            end
          end
        end
      end
      S_W_LD: begin
        if (idx_q < COL_C) begin
          if (!l0_full) begin
            xmem_cen_p0  = 1'b0;
            xmem_addr_p0 = wbase_q + ext_addr(idx_q);
            idx_n        = idx_q + ONE_C;
          end
        end else begin
          state_n = S_K_LD;
          idx_n   = '0;
        end
      end
      S_K_LD: begin
        inst_p0[3] = 1'b1;
        inst_p0[0] = 1'b1;
        if (idx_q == COL_LAST) begin
          state_n = S_K_GAP;
          idx_n   = '0;
        end else begin
          idx_n = idx_q + ONE_C;
        end
      end
      S_K_GAP: begin
        if (idx_q == GAP_LAST) begin
          state_n = S_A_LD;
          idx_n   = '0;
        end else begin
          idx_n = idx_q + ONE_C;
        end
      end
      S_A_LD: begin
        if (idx_q < n_act_q) begin
          if (!l0_full) begin
            xmem_cen_p0  = 1'b0;
            xmem_addr_p0 = ext_addr(idx_q);
            idx_n        = idx_q + ONE_C;
          end
        end else begin
          state_n = S_EXEC;
          idx_n   = '0;
        end
      end
      S_EXEC: begin
        inst_p0[3] = 1'b1;
        inst_p0[1] = 1'b1;
        if (idx_q == n_act_q - ONE_C) begin
          state_n = S_DRAIN;
          idx_n   = '0;
        end else begin
          idx_n = idx_q + ONE_C;
        end
      end
      S_DRAIN: begin
        if (idx_q < n_act_q) begin
          if (ofifo_valid) begin
            inst_p0[6] = 1'b1;
            pend_n     = pbase_q + ext_addr(idx_q);
            idx_n      = idx_q + ONE_C;
          end
        end else if (mode_q) begin
          state_n = S_DONE;
        end else if (({1'b0, kij_q} + (cnt_bw+1)'(1)) < {1'b0, n_kij_q}) begin
          state_n = S_W_LD;
          kij_n   = kij_q + ONE_C;
          wbase_n = wbase_q + COL_A;
          pbase_n = pbase_q + ext_addr(n_act_q);
          idx_n   = '0;
        end else begin
          state_n = S_ACC_RD;
          idx_n   = '0;
          o_n     = '0;
          aaddr_n = '0;
        end
      end
      // aaddr walks k*n_act+o; after n_kij reads it lands on the write-back slot.
      S_ACC_RD: begin
        pmem_cen_p0  = 1'b0;
        pmem_wen_p0  = 1'b1;
        pmem_addr_p0 = aaddr_q;
        aaddr_n      = aaddr_q + ext_addr(n_act_q);
        if (idx_q == n_kij_q - ONE_C) begin
          state_n = S_ACC_WAIT;
          idx_n   = '0;
        end else begin
          idx_n = idx_q + ONE_C;
        end
      end
      S_ACC_WAIT: begin
        state_n = S_ACC_WB;
      end
      S_ACC_WB: begin
        pmem_cen_p0  = 1'b0;
        pmem_wen_p0  = 1'b0;
        pmem_addr_p0 = aaddr_q;
        if (o_q == n_act_q - ONE_C) begin
          state_n = S_DONE;
        end else begin
          state_n = S_ACC_RD;
          o_n     = o_q + ONE_C;
          aaddr_n = ext_addr(o_q + ONE_C);
        end
      end
      S_DONE: begin
        done_p0 = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_p0     = (state_n != S_IDLE);
    inst_p0[34] = mode_n & busy_p0;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      inst      <= '0;
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inst      <= inst_p0;
      xmem_cen  <= xmem_cen_p0;
      xmem_addr <= xmem_addr_p0;
      pmem_cen  <= pmem_cen_p0;
      pmem_wen  <= pmem_wen_p0;
      pmem_addr <= pmem_addr_p0;
      busy      <= busy_p0;
      done      <= done_p0;
    end
  end

`ifdef CORELET_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic stall_now;

  always_comb begin
    stall_now = 1'b0;
    if (state_q == S_W_LD && idx_q < COL_C && l0_full)           stall_now = 1'b1;
    if (state_q == S_A_LD && idx_q < n_act_q && l0_full)         stall_now = 1'b1;
    if (state_q == S_DRAIN && idx_q < n_act_q && !ofifo_valid)   stall_now = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (stall_now) begin
      stall_cnt <= sat_inc32(stall_cnt);
    end
  end
`endif

endmodule
